// File: rtl/hdl_1.sv
// Four-input Boolean function unit: F = table[{A,B,C,D}], plus a registered copy and a hit counter.
// Define HDL1_TT_PROG_EN to make the truth table writable through tt_wr/tt_data.
module hdl_1 #(
   parameter logic [15:0] TT    = 16'h8B8B,
   parameter int          CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             A,
   input  logic             B,
   input  logic             C,
   input  logic             D,
   input  logic             in_valid,
`ifdef HDL1_TT_PROG_EN
   input  logic             tt_wr,
   input  logic [15:0]      tt_data,
`endif
   output logic             F,
   output logic             F_q,
   output logic             out_valid,
   output logic [CNT_W-1:0] hit_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [15:0] tbl;
   logic [3:0]  idx;

`ifdef HDL1_TT_PROG_EN
   // A write lands on the edge, so a same-cycle sample still sees the old table.
   always_ff @(posedge clk) begin
      if (rst) begin
         tbl <= TT;
      end else if (tt_wr) begin
         tbl <= tt_data;
      end
   end
`else
   assign tbl = TT;
`endif

   assign idx = {A, B, C, D};
   assign F   = tbl[idx];

   always_ff @(posedge clk) begin
      if (rst) begin
         F_q       <= 1'b0;
         out_valid <= 1'b0;
         hit_cnt   <= '0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            F_q <= F;
            if (F && (hit_cnt != CNT_MAX)) begin
               hit_cnt <= hit_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_hdl_1.sv
// Directed bench for hdl_1: truth-table sweep, reset, registered path,
// counter saturation (CNT_W=2 instance), mid-stream reset, optional table write.
module tb_hdl_1;

   logic       clk = 1'b0;
   logic       rst;
   logic       A, B, C, D;
   logic       in_valid;
   logic       F, F_q, out_valid;
   logic [7:0] hit_cnt;
   logic       F_s, F_q_s, out_valid_s;
   logic [1:0] hit_cnt_s;
`ifdef HDL1_TT_PROG_EN
   logic        tt_wr;
   logic [15:0] tt_data;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      logic [3:0] in;
      logic       f;
   } vec_t;

   vec_t vec [16];

   always #5 clk = ~clk;

   hdl_1 dut (
      .clk       (clk),
      .rst       (rst),
      .A         (A),
      .B         (B),
      .C         (C),
      .D         (D),
      .in_valid  (in_valid),
`ifdef HDL1_TT_PROG_EN
      .tt_wr     (tt_wr),
      .tt_data   (tt_data),
`endif
      .F         (F),
      .F_q       (F_q),
      .out_valid (out_valid),
      .hit_cnt   (hit_cnt)
   );

   hdl_1 #(.CNT_W(2)) dut_s (
      .clk       (clk),
      .rst       (rst),
      .A         (A),
      .B         (B),
      .C         (C),
      .D         (D),
      .in_valid  (in_valid),
`ifdef HDL1_TT_PROG_EN
      .tt_wr     (1'b0),
      .tt_data   (16'h0000),
`endif
      .F         (F_s),
      .F_q       (F_q_s),
      .out_valid (out_valid_s),
      .hit_cnt   (hit_cnt_s)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic set_in(input logic [3:0] v);
      {A, B, C, D} = v;
   endtask

   // Advance one edge and land 1 ns after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   int exp_cnt;

   initial begin
      vec[0]  = '{4'd0,  1'b1};
      vec[1]  = '{4'd1,  1'b1};
      vec[2]  = '{4'd2,  1'b0};
      vec[3]  = '{4'd3,  1'b1};
      vec[4]  = '{4'd4,  1'b0};
      vec[5]  = '{4'd5,  1'b0};
      vec[6]  = '{4'd6,  1'b0};
      vec[7]  = '{4'd7,  1'b1};
      vec[8]  = '{4'd8,  1'b1};
      vec[9]  = '{4'd9,  1'b1};
      vec[10] = '{4'd10, 1'b0};
      vec[11] = '{4'd11, 1'b1};
      vec[12] = '{4'd12, 1'b0};
      vec[13] = '{4'd13, 1'b0};
      vec[14] = '{4'd14, 1'b0};
      vec[15] = '{4'd15, 1'b1};

      rst      = 1'b1;
      in_valid = 1'b1;
      set_in(4'd5);
`ifdef HDL1_TT_PROG_EN
      tt_wr   = 1'b0;
      tt_data = 16'h0000;
`endif

      // Reset for two cycles with inputs toggling.
      tick();
      chk("rst_F_q", F_q, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_hit_cnt", hit_cnt, 0);
      chk("rst_F_tracks5", F, 0);
      set_in(4'd9);
      tick();
      chk("rst2_F_q", F_q, 0);
      chk("rst2_out_valid", out_valid, 0);
      chk("rst2_hit_cnt", hit_cnt, 0);
      chk("rst2_F_tracks9", F, 1);

      // Combinational sweep, nothing accepted.
      rst      = 1'b0;
      in_valid = 1'b0;
      for (int i = 0; i < 16; i++) begin
         set_in(vec[i].in);
         #1;
         chk($sformatf("sweep_F[%0d]", i), F, vec[i].f);
         tick();
         chk($sformatf("sweep_ov[%0d]", i), out_valid, 0);
         chk($sformatf("sweep_cnt[%0d]", i), hit_cnt, 0);
      end

      // Back-to-back accepted sweep.
      exp_cnt  = 0;
      in_valid = 1'b1;
      for (int i = 0; i < 16; i++) begin
         set_in(vec[i].in);
         if (vec[i].f) exp_cnt++;
         tick();
         chk($sformatf("pipe_F_q[%0d]", i), F_q, vec[i].f);
         chk($sformatf("pipe_ov[%0d]", i), out_valid, 1);
         chk($sformatf("pipe_cnt[%0d]", i), hit_cnt, exp_cnt);
      end
      chk("pipe_final_cnt", hit_cnt, 8);
      in_valid = 1'b0;
      set_in(4'd2);
      tick();
      chk("idle_ov", out_valid, 0);
      chk("idle_F_q_hold", F_q, 1);
      chk("idle_cnt_hold", hit_cnt, 8);

      // Saturation on the 2-bit counter instance.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("sat_rst_cnt", hit_cnt_s, 0);
      set_in(4'd0);
      in_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk($sformatf("sat_cnt[%0d]", i), hit_cnt_s, (i < 3) ? i + 1 : 3);
         chk($sformatf("wide_cnt[%0d]", i), hit_cnt, i + 1);
      end
      in_valid = 1'b0;

      // Reset pulsed mid-sweep at input 7.
      rst = 1'b1;
      tick();
      rst      = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 7; i++) begin
         set_in(vec[i].in);
         tick();
      end
      chk("mid_pre_cnt", hit_cnt, 3);
      set_in(4'd7);
      rst = 1'b1;
      tick();
      chk("mid_rst_F_q", F_q, 0);
      chk("mid_rst_ov", out_valid, 0);
      chk("mid_rst_cnt", hit_cnt, 0);
      rst = 1'b0;
      for (int i = 8; i < 16; i++) begin
         set_in(vec[i].in);
         tick();
      end
      chk("mid_restart_cnt", hit_cnt, 4);
      chk("mid_restart_F_q", F_q, 1);
      in_valid = 1'b0;

`ifdef HDL1_TT_PROG_EN
      // Write collides with a sample: sample uses the old table.
      set_in(4'd1);
      in_valid = 1'b1;
      tt_wr    = 1'b1;
      tt_data  = 16'h0001;
      tick();
      tt_wr    = 1'b0;
      in_valid = 1'b0;
      chk("prog_old_tbl_F_q", F_q, 1);
      set_in(4'd0);
      #1;
      chk("prog_F_in0", F, 1);
      set_in(4'd1);
      #1;
      chk("prog_F_in1", F, 0);
      set_in(4'd3);
      #1;
      chk("prog_F_in3", F, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk("prog_rst_reload", F, 1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
